bin2bcd_seq: RTL
================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL expose parameter IN_W, default 32, binary input width.
REQ-002 The block SHALL expose parameter DIGITS, default 4, number of BCD output digits.
REQ-003 Port clk  input  1  system clock (100 MHz board clock).
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  single-cycle request to convert bin_in.
REQ-006 Port bin_in  input  IN_W  unsigned binary value to convert (e.g. GCD result).
REQ-007 Port busy  output  1  high while a conversion is in progress.
REQ-008 Port valid  output  1  single-cycle pulse when bcd_out and ovf are updated.
REQ-009 Port bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
REQ-010 Port ovf  output  1  bin_in of last accepted conversion was >= 10^DIGITS.
REQ-011 Port blank  output  DIGITS  per-digit leading-zero blank mask (exists only with BCD_BLANK_EN).

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-013 In IDLE, start=1 SHALL latch bin_in into a shift register, clear the BCD scratch register, load the bit counter with IN_W, and move to SHIFT.
REQ-014 In IDLE, start=0 SHALL leave all outputs unchanged.
REQ-015 In SHIFT, each cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit, and decrement the counter.
REQ-016 When the counter reaches 0 after the IN_W-th shift, the FSM SHALL go to DONE.
REQ-017 In DONE, the block SHALL register bcd_out and ovf, assert valid for exactly one cycle, and return to IDLE.
REQ-018 Latency: start sampled at edge N SHALL give valid=1 in the cycle following edge N+IN_W+1; at defaults, 34 cycles from start to valid.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored with no queuing; bin_in is sampled only at acceptance.
REQ-021 ovf SHALL be decided by comparing the latched value with the constant 10^DIGITS at acceptance.
REQ-022 When ovf=1, bcd_out SHALL saturate to all digits 9.
REQ-023 bcd_out, ovf and blank SHALL hold their values between valid pulses.
REQ-024 start asserted in the same cycle valid is high SHALL not be accepted until IDLE is reached on the following edge.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, with busy=0, valid=0, bcd_out=0, ovf=0, blank=0, and clear the counter and scratch registers.
REQ-026 Reset mid-conversion SHALL abort the conversion without a valid pulse; the first start after release SHALL be converted normally.

Configuration
REQ-027 With macro BCD_BLANK_EN defined, blank[i] SHALL be 1 when digit i and all higher digits are 0, for i>=1.
REQ-028 With BCD_BLANK_EN defined, blank[0] SHALL always be 0, and blank SHALL be registered together with bcd_out.
REQ-029 Without BCD_BLANK_EN, port blank and its logic SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), the BCD digit width constant (4), and the add-3 threshold constant (5).
REQ-031 One sub-module, bcd_add3_cell (single-digit conditional add-3), SHALL be instantiated DIGITS times; no other sub-modules.

Verification
REQ-032 bin_in=0, start pulse -> valid after 34 cycles, bcd_out=0x0000, ovf=0.
REQ-033 bin_in=99 -> bcd_out=0x0099, ovf=0; with BCD_BLANK_EN, blank=4'b1100.
REQ-034 bin_in=9999 -> bcd_out=0x9999, ovf=0; bin_in=10000 -> bcd_out=0x9999, ovf=1.
REQ-035 start with bin_in=12, then start with bin_in=34 ten cycles later -> one valid only, bcd_out=0x0012, and busy stays high throughout.
REQ-036 rst_n low for 2 cycles at cycle 15 of a conversion -> no valid pulse, all outputs 0; a new start with bin_in=7 -> bcd_out=0x0007.
REQ-037 bin_in=0xFFFFFFFF -> ovf=1, bcd_out=0x9999, and the valid pulse is exactly 1 cycle wide.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (definitions only). Backpressure: n/a.
// Optional blanking output is enabled by defining BCD_BLANK_EN.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // 10^n as a 64-bit constant; used to size the overflow limit at elaboration.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int i = 0; i < n; i++) begin
      acc = acc * 64'd10;
    end
    return acc;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Single BCD digit conditional add-3 (double-dabble correction step).
// Latency: combinational. Backpressure: none.
// Digits at or above the threshold get +3 so the next left shift carries correctly.
module bcd_add3_cell
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_THRESH) ? (digit_i + BCD_DIGIT_W'(3)) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle; BCD_BLANK_EN adds blank mask.
// Latency: start sampled at edge N gives valid in the cycle after edge N+IN_W+1.
// Backpressure: none; start is ignored while busy, results hold until the next valid.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int          BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int          CNT_W     = $clog2(IN_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  state_t            state_q, state_d;
  logic [IN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [BCD_W-1:0]  scratch_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_lat_q, ovf_lat_d;
  logic              valid_q, valid_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [BCD_W-1:0]  bcd_final;
  logic              in_ovf;

  // Overflow is judged on the raw input at acceptance, not on the truncated scratch.
  assign in_ovf    = (64'(bin_in) >= OVF_LIMIT);
  assign bcd_final = ovf_lat_q ? {DIGITS{4'h9}} : scratch_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_cell u_add3 (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_calc;
  logic              zero_run;

  always_comb begin
    blank_calc = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (bcd_final[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_calc[i] = zero_run;
    end
  end

  assign blank = blank_q;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
`ifdef BCD_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(IN_W);
          ovf_lat_d = in_ovf;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The counter-exhausted cycle performs no shift; results are captured on entry to DONE.
        if (cnt_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
          bcd_d   = bcd_final;
          ovf_d   = ovf_lat_q;
`ifdef BCD_BLANK_EN
          blank_d = blank_calc;
`endif
        end else begin
          {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
          cnt_d                = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_lat_q <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BCD_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

  assign busy    = (state_q != IDLE);
  assign valid   = valid_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule
